// File: rtl/gate_tt_sequencer.sv
// Truth-table sweeper: drives every input vector to a gate under test, waits SETTLE cycles, and checks y_in against EXPECT.
// Optional macro GATE_TT_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module gate_tt_sequencer #(
    parameter int                     N_IN   = 2,
    parameter int                     SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]   EXPECT = 4'b1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   a_out,
    input  logic              y_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_cnt,
    output logic [N_IN-1:0]   first_fail
);

    localparam int              NV          = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_VEC    = N_IN'(NV - 1);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

`ifdef GATE_TT_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              exp_bit;
    logic              mismatch;

    // Case inequality so that an X or Z from the gate counts as a mismatch.
    always_comb begin
        exp_bit  = EXPECT[vec_q];
        mismatch = (y_in !== exp_bit);
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ff_d    = ff_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        ff_d = vec_q;
                    end
                end
                if ((vec_q == LAST_VEC) || (STOP_ON_FAIL && mismatch)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = ST_SETTLE;
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    assign a_out      = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;

endmodule
